// File: rtl/calc_pkg.sv
// Shared types and elaboration helpers for the calculator datapath.
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  function automatic int calc_chunks(input int n, input int w);
    return n / w;
  endfunction

  function automatic bit calc_width_ok(input int n, input int w);
    return (w > 0) && (n >= w) && ((n % w) == 0);
  endfunction

endpackage

// File: rtl/borrow_lookahead_chunk.sv
// Combinational W-bit borrow-lookahead subtract slice: d = a - b - bi.
// Each internal borrow is a flat sum of products of generate/propagate terms.
module borrow_lookahead_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bi,
  output logic [W-1:0] d,
  output logic         bo,
  output logic         msb_bi
);

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W:0]   br;

  assign g     = ~a & b;
  assign p     = ~(a ^ b);
  assign br[0] = bi;

  for (genvar gi = 0; gi < W; gi++) begin : g_borrow
    logic br_next;

    // br[gi+1] = g[gi] | p[gi]g[gi-1] | ... | p[gi..0]bi, built term by term.
    always_comb begin
      logic acc;
      logic pp;
      acc = 1'b0;
      pp  = 1'b1;
      for (int m = gi; m >= 0; m--) begin
        acc = acc | (pp & g[m]);
        pp  = pp & p[m];
      end
      br_next = acc | (pp & bi);
    end

    assign br[gi+1] = br_next;
  end

  assign d      = a ^ b ^ br[W-1:0];
  assign bo     = br[W];
  assign msb_bi = br[W-1];

endmodule

// File: rtl/borrow_lookahead_subtractor.sv
// Multi-cycle N-bit subtractor, one W-bit lookahead chunk per clock.
// Optional ovf output is enabled by defining SUB_OVF_EN.
module borrow_lookahead_subtractor
  import calc_pkg::*;
#(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Diff,
`ifdef SUB_OVF_EN
  output logic         ovf,
`endif
  output logic         bout
);

  localparam int CHUNKS = calc_chunks(N, W);
  localparam int KW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(CHUNKS - 1);

  if (!calc_width_ok(N, W)) begin : g_bad_width
    $error("borrow_lookahead_subtractor: N must be a positive multiple of W");
  end

  sub_state_t    state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic          borrow_q, borrow_d;
  logic [N-1:0]  diff_q, diff_d;
  logic          bout_q, bout_d;

  logic [W-1:0]  chunk_a;
  logic [W-1:0]  chunk_b;
  logic [W-1:0]  chunk_d;
  logic          chunk_bo;
  logic          chunk_msb_bi;

  assign chunk_a = a_q[int'(k_q)*W +: W];
  assign chunk_b = b_q[int'(k_q)*W +: W];

  borrow_lookahead_chunk #(.W(W)) u_chunk (
    .a      (chunk_a),
    .b      (chunk_b),
    .bi     (borrow_q),
    .d      (chunk_d),
    .bo     (chunk_bo),
    .msb_bi (chunk_msb_bi)
  );

`ifdef SUB_OVF_EN
  logic ovf_q, ovf_d;
`else
  logic unused_msb_bi;
  assign unused_msb_bi = chunk_msb_bi;
`endif

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
`ifdef SUB_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        // A start seen in DONE chains straight into the next operation.
        if (start) begin
          a_d      = A;
          b_d      = B;
          borrow_d = bin;
          k_d      = '0;
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        diff_d[int'(k_q)*W +: W] = chunk_d;
        borrow_d = chunk_bo;
        if (k_q == K_LAST) begin
          bout_d  = chunk_bo;
`ifdef SUB_OVF_EN
          ovf_d   = chunk_msb_bi ^ chunk_bo;
`endif
          k_d     = '0;
          state_d = DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      k_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
`ifdef SUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
`ifdef SUB_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign Diff = diff_q;
  assign bout = bout_q;
`ifdef SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_borrow_lookahead_subtractor.sv
// Self-checking bench for borrow_lookahead_subtractor (N=16, W=4); checks ovf when SUB_OVF_EN is defined.
module tb_borrow_lookahead_subtractor;

  localparam int N = 16;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] A = '0;
  logic [N-1:0] B = '0;
  logic         bin = 1'b0;
  logic         busy;
  logic         done;
  logic [N-1:0] Diff;
  logic         bout;
`ifdef SUB_OVF_EN
  logic         ovf;
`endif

  int errors = 0;
  int checks = 0;

  borrow_lookahead_subtractor #(.N(N), .W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .A     (A),
    .B     (B),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .Diff  (Diff),
`ifdef SUB_OVF_EN
    .ovf   (ovf),
`endif
    .bout  (bout)
  );

  always #5 clk = ~clk;

  // Reference: plain wide arithmetic, borrow is the sign bit of the 17-bit result.
  function automatic logic [N:0] ref_sub(input logic [N-1:0] a, input logic [N-1:0] b, input logic bi);
    return {1'b0, a} - {1'b0, b} - {{N{1'b0}}, bi};
  endfunction

  function automatic logic ref_ovf(input logic [N-1:0] a, input logic [N-1:0] b, input logic bi);
    int signed r;
    r = $signed({{(32-N){a[N-1]}}, a}) - $signed({{(32-N){b[N-1]}}, b}) - int'(bi);
    return (r > 32767) || (r < -32768);
  endfunction

  // Drive a start pulse; returns positioned at the negedge of busy cycle 1.
  task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic bi);
    A = a; B = b; bin = bi; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) for done; cyc is the cycle at which done was seen.
  task automatic wait_done(output int cyc, output int busy_cnt);
    cyc = 1;
    busy_cnt = 0;
    while (!done && cyc < 20) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({busy, done, bout} !== 3'b000 || Diff !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b bout=%b Diff=%h, required all zero", busy, done, bout, Diff);
    end
    $display("reset: busy=%b done=%b Diff=%h bout=%b", busy, done, Diff, bout);
  endtask

  task automatic test_basic();
    logic [N-1:0] va [4] = '{16'h1234, 16'h0000, 16'h0005, 16'h8000};
    logic [N-1:0] vb [4] = '{16'h0234, 16'h0001, 16'h0005, 16'h0001};
    logic         vi [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [N-1:0] ed [4] = '{16'h1000, 16'hFFFF, 16'hFFFF, 16'h7FFF};
    logic         eb [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    int cyc, bc;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start_op(va[i], vb[i], vi[i]);
      wait_done(cyc, bc);
      checks++;
      if (done !== 1'b1 || cyc != 5) begin
        errors++;
        $display("FAIL basic%0d_latency: done=%b at cycle %0d, required done=1 at cycle 5", i, done, cyc);
      end
      checks++;
      if (bc != 4) begin
        errors++;
        $display("FAIL basic%0d_busy: busy for %0d cycles, required 4", i, bc);
      end
      checks++;
      if (Diff !== ed[i] || bout !== eb[i]) begin
        errors++;
        $display("FAIL basic%0d_result: Diff=%h bout=%b, required Diff=%h bout=%b", i, Diff, bout, ed[i], eb[i]);
      end
`ifdef SUB_OVF_EN
      checks++;
      if (ovf !== ref_ovf(va[i], vb[i], vi[i])) begin
        errors++;
        $display("FAIL basic%0d_ovf: ovf=%b, required %b", i, ovf, ref_ovf(va[i], vb[i], vi[i]));
      end
`endif
      $display("basic%0d: A=%h B=%h bin=%b -> Diff=%h bout=%b cycles=%0d", i, va[i], vb[i], vi[i], Diff, bout, cyc);
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || Diff !== ed[i] || bout !== eb[i]) begin
        errors++;
        $display("FAIL basic%0d_hold: done=%b Diff=%h bout=%b, required done=0 Diff=%h bout=%b", i, done, Diff, bout, ed[i], eb[i]);
      end
    end
  endtask

  task automatic test_ignore_start();
    int cyc, bc;
    @(negedge clk);
    start_op(16'h4321, 16'h0321, 1'b0);
    A = 16'h0001; B = 16'h0002; bin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, bc);
    checks++;
    if (done !== 1'b1 || Diff !== 16'h4000 || bout !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start: done=%b Diff=%h bout=%b, required done=1 Diff=4000 bout=0", done, Diff, bout);
    end
    $display("ignore_start: Diff=%h bout=%b", Diff, bout);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL ignore_idle: busy=%b done=%b, required both 0 (no queued op)", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, bc;
    @(negedge clk);
    start_op(16'h1234, 16'h0234, 1'b0);
    wait_done(cyc, bc);
    start_op(16'h0010, 16'h0001, 1'b0);
    wait_done(cyc, bc);
    checks++;
    if (done !== 1'b1 || cyc != 5 || Diff !== 16'h000F || bout !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back: done=%b cycle=%0d Diff=%h bout=%b, required done=1 cycle=5 Diff=000f bout=0", done, cyc, Diff, bout);
    end
    $display("back_to_back: Diff=%h bout=%b cycles=%0d", Diff, bout, cyc);
    @(negedge clk);
  endtask

  task automatic test_reset_midrun();
    int cyc, bc;
    @(negedge clk);
    start_op(16'h00FF, 16'h0001, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({busy, done, bout} !== 3'b000 || Diff !== '0) begin
      errors++;
      $display("FAIL reset_midrun: busy=%b done=%b bout=%b Diff=%h, required all zero", busy, done, bout, Diff);
    end
    start_op(16'h0003, 16'h0005, 1'b0);
    wait_done(cyc, bc);
    checks++;
    if (done !== 1'b1 || cyc != 5 || Diff !== 16'hFFFE || bout !== 1'b1) begin
      errors++;
      $display("FAIL after_reset_op: done=%b cycle=%0d Diff=%h bout=%b, required done=1 cycle=5 Diff=fffe bout=1", done, cyc, Diff, bout);
    end
    $display("reset_midrun: post-reset Diff=%h bout=%b", Diff, bout);
    @(negedge clk);
  endtask

  task automatic test_random();
    int cyc, bc;
    int rerr = 0;
    logic [N-1:0] ra, rb;
    logic         ri;
    logic [N:0]   exp;
    @(negedge clk);
    for (int i = 0; i < 10000; i++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      ri = 1'($urandom);
      exp = ref_sub(ra, rb, ri);
      start_op(ra, rb, ri);
      wait_done(cyc, bc);
      checks++;
      if (done !== 1'b1 || cyc != 5) begin
        errors++;
        $display("FAIL random%0d_timing: done=%b at cycle %0d, required cycle 5", i, done, cyc);
        break;
      end
      checks++;
      if ({bout, Diff} !== exp) begin
        errors++;
        rerr++;
        $display("FAIL random%0d_result: A=%h B=%h bin=%b Diff=%h bout=%b, required Diff=%h bout=%b", i, ra, rb, ri, Diff, bout, exp[N-1:0], exp[N]);
      end
`ifdef SUB_OVF_EN
      checks++;
      if (ovf !== ref_ovf(ra, rb, ri)) begin
        errors++;
        rerr++;
        $display("FAIL random%0d_ovf: A=%h B=%h bin=%b ovf=%b, required %b", i, ra, rb, ri, ovf, ref_ovf(ra, rb, ri));
      end
`endif
      if (rerr > 20) break;
    end
    $display("random: sweep finished, %0d result errors", rerr);
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ignore_start();
    test_back_to_back();
    test_reset_midrun();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
